// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Matrix-keypad scanner. Drives a one-hot row sweep, samples the column
//   inputs once per row dwell, debounces over whole scan frames and emits one
//   key event per press, with optional auto-repeat while the key is held.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   in         column sense lines (bit c high while key (driven row, c) pressed)
//   repeat_en  1 = auto-repeat events while a key is held
//   row_sweep  one-hot, active-high row drive
//   key_valid  one-cycle key event pulse
//   key_code   accepted key index, row*COLS+col
//   key_held   high while the accepted key is held
module keypad_scan_ctrl #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_DELAY    = 25,
    parameter int unsigned REPEAT_RATE     = 5,
    localparam int unsigned KEY_W          = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  in,
    input  logic             repeat_en,
    output logic [ROWS-1:0]  row_sweep,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_held
);

    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned ROW_W    = $clog2(ROWS);
    localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DEB_W    = $clog2(DEBOUNCE_FRAMES + 1);
    // Hold count saturates at the first-repeat point; later repeats are
    // paced by a separate phase counter, so nothing wraps during a long hold.
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > 1) ? REPEAT_DELAY : 1;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned RATE_W   = $clog2(REPEAT_RATE + 1);

    typedef enum logic [1:0] {StIdle, StConfirm, StHeld} state_e;

    // Input synchroniser
    logic [COLS-1:0] in_meta_q, in_sync_q;

    // Scan timing
    logic [CNT_W-1:0] cnt_q;
    logic [ROWS-1:0]  row_sweep_q;
    logic [ROW_W-1:0] row_idx_q;
    logic             sample;
    logic             frame_end;

    // Per-frame candidate accumulation
    logic             acc_found_q;
    logic [KEY_W-1:0] acc_code_q;
    logic             cur_any;
    logic [COL_W-1:0] cur_col;
    logic [KEY_W-1:0] row_code;
    logic             frame_found;
    logic [KEY_W-1:0] frame_code;

    // Debounce / repeat FSM
    state_e            state_q, state_d;
    logic [KEY_W-1:0]  cand_q, cand_d;
    logic [DEB_W-1:0]  match_q, match_d;
    logic [DEB_W-1:0]  rel_q, rel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RATE_W-1:0] phase_q, phase_d;
    logic              key_valid_q, key_valid_d;
    logic [KEY_W-1:0]  key_code_q, key_code_d;
    logic              key_held_q, key_held_d;
    logic              accept;
    logic              rep_point;
    logic [DEB_W-1:0]  match_inc, rel_inc;
    logic [RATE_W-1:0] phase_inc;

    assign sample    = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frame_end = sample && (row_idx_q == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_meta_q <= '0;
            in_sync_q <= '0;
        end else begin
            in_meta_q <= in;
            in_sync_q <= in_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            row_sweep_q <= ROWS'(1);
            row_idx_q   <= '0;
        end else if (sample) begin
            cnt_q       <= '0;
            row_sweep_q <= {row_sweep_q[ROWS-2:0], row_sweep_q[ROWS-1]};
            row_idx_q   <= frame_end ? '0 : row_idx_q + ROW_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Lowest pressed column in the current row
    always_comb begin
        cur_any = |in_sync_q;
        cur_col = '0;
        for (int c = int'(COLS) - 1; c >= 0; c--) begin
            if (in_sync_q[c]) cur_col = COL_W'(c);
        end
        row_code = KEY_W'(int'(row_idx_q) * int'(COLS) + int'(cur_col));
    end

    // Rows are visited in ascending order, so the first hit of a frame is the
    // lowest index; the last row is merged combinationally at frame end.
    assign frame_found = acc_found_q | cur_any;
    assign frame_code  = acc_found_q ? acc_code_q : row_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_found_q <= 1'b0;
            acc_code_q  <= '0;
        end else if (sample) begin
            if (frame_end) begin
                acc_found_q <= 1'b0;
                acc_code_q  <= '0;
            end else if (!acc_found_q && cur_any) begin
                acc_found_q <= 1'b1;
                acc_code_q  <= row_code;
            end
        end
    end

    assign match_inc = match_q + DEB_W'(1);
    assign rel_inc   = rel_q + DEB_W'(1);
    assign phase_inc = phase_q + RATE_W'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        match_d     = match_q;
        rel_d       = rel_q;
        hold_d      = hold_q;
        phase_d     = phase_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        accept      = 1'b0;
        rep_point   = 1'b0;

        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_found) begin
                        cand_d  = frame_code;
                        match_d = DEB_W'(1);
                        if (DEBOUNCE_FRAMES <= 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StConfirm;
                        end
                    end
                end
                StConfirm: begin
                    if (!frame_found) begin
                        state_d = StIdle;
                        match_d = '0;
                    end else if (frame_code == cand_q) begin
                        if (match_inc == DEB_W'(DEBOUNCE_FRAMES)) begin
                            accept = 1'b1;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        cand_d  = frame_code;
                        match_d = DEB_W'(1);
                    end
                end
                StHeld: begin
                    if (frame_found && (frame_code == cand_q)) begin
                        rel_d = '0;
                        if (hold_q < HOLD_W'(HOLD_MAX)) begin
                            hold_d = hold_q + HOLD_W'(1);
                            if (hold_d == HOLD_W'(HOLD_MAX)) rep_point = 1'b1;
                        end else if (phase_inc == RATE_W'(REPEAT_RATE)) begin
                            rep_point = 1'b1;
                            phase_d   = '0;
                        end else begin
                            phase_d = phase_inc;
                        end
                        key_valid_d = rep_point && repeat_en;
                    end else if (rel_inc == DEB_W'(DEBOUNCE_FRAMES)) begin
                        state_d    = StIdle;
                        key_held_d = 1'b0;
                        rel_d      = '0;
                        match_d    = '0;
                    end else begin
                        rel_d = rel_inc;
                    end
                end
                default: state_d = StIdle;
            endcase

            // The accepting frame counts as the first hold frame.
            if (accept) begin
                state_d     = StHeld;
                key_valid_d = 1'b1;
                key_code_d  = cand_d;
                key_held_d  = 1'b1;
                match_d     = '0;
                rel_d       = '0;
                hold_d      = HOLD_W'(1);
                phase_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            match_q     <= '0;
            rel_q       <= '0;
            hold_q      <= '0;
            phase_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_sweep = row_sweep_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: 4x4 matrix, 4-cycle dwell, 3-frame debounce,
// repeat delay 4 / rate 2. Key matrix is modelled from row_sweep; expected
// events come from a frame-level model of the press/hold/release rules.
module tb_keypad_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DEB  = 3;
    localparam int RD   = 4;
    localparam int RR   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_in;
    logic        repeat_en;
    logic [3:0]  row_sweep;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic [15:0] mat;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Frame-level reference model state
    int m_acc_key;   // accepted key, -1 when nothing held
    int m_cand;      // key being confirmed
    int m_run;       // consecutive frames m_cand has been seen
    int m_rel;       // consecutive frames the accepted key has been missing
    int m_hold;      // frames the accepted key has been held
    bit exp_valid;
    bit exp_held;
    int exp_code;

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .in(col_in),
        .repeat_en(repeat_en),
        .row_sweep(row_sweep),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sweep[r]) col_in = col_in | mat[r*COLS +: COLS];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lowest_key(input logic [15:0] m);
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_acc_key = -1;
        m_cand    = -1;
        m_run     = 0;
        m_rel     = 0;
        m_hold    = 0;
        exp_valid = 1'b0;
        exp_held  = 1'b0;
        exp_code  = 0;
    endtask

    task automatic model_step(input int cand, input bit ren);
        exp_valid = 1'b0;
        if (m_acc_key < 0) begin
            if (cand < 0) begin
                m_run = 0;
            end else if (m_run > 0 && cand == m_cand) begin
                m_run++;
            end else begin
                m_cand = cand;
                m_run  = 1;
            end
            if (m_run >= DEB) begin
                m_acc_key = m_cand;
                m_hold    = 1;
                m_rel     = 0;
                m_run     = 0;
                exp_valid = 1'b1;
                exp_code  = m_cand;
            end
        end else if (cand == m_acc_key) begin
            m_rel = 0;
            m_hold++;
            if (ren && m_hold >= RD && ((m_hold - RD) % RR) == 0) exp_valid = 1'b1;
        end else begin
            m_rel++;
            if (m_rel == DEB) begin
                m_acc_key = -1;
                m_run     = 0;
            end
        end
        exp_held = (m_acc_key >= 0);
    endtask

    // One full frame with a fixed key matrix; checks at the cycle after frame end.
    task automatic run_frame(input logic [15:0] m, input bit ren, input string tag);
        int stray;
        stray     = 0;
        mat       = m;
        repeat_en = ren;
        for (int j = 1; j < ROWS * 4; j++) begin
            @(posedge clk);
            #1;
            if (key_valid) stray++;
        end
        @(posedge clk);
        #1;
        model_step(lowest_key(m), ren);
        check({tag, ".stray"}, stray, 0);
        check({tag, ".valid"}, key_valid, exp_valid);
        check({tag, ".held"}, key_held, exp_held);
        check({tag, ".code"}, key_code, exp_code);
        if (key_valid) pulses++;
    endtask

    initial begin
        logic [15:0] rm;
        bit          ren;
        int          k;

        rst       = 1'b0;
        mat       = '0;
        repeat_en = 1'b0;
        model_reset();

        // 1: reset values, then row rotation
        repeat (3) @(posedge clk);
        #1;
        check("rst.row", row_sweep, 4'b0001);
        check("rst.valid", key_valid, 0);
        check("rst.held", key_held, 0);
        check("rst.code", key_code, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            check("scan.row", row_sweep, 4'b0001 << ((c / 4) % 4));
        end
        model_step(-1, 1'b0);
        check("scan.valid", key_valid, 0);

        // 2: single press of (2,2), no repeat
        pulses = 0;
        for (int f = 0; f < 6; f++) run_frame(16'(1) << 10, 1'b0, "hold22");
        run_frame('0, 1'b0, "rel22a");
        run_frame('0, 1'b0, "rel22b");
        check("rel22b.still_held", key_held, 1);
        run_frame('0, 1'b0, "rel22c");
        check("hold22.pulses", pulses, 1);
        check("hold22.code", key_code, 10);
        check("rel22c.dropped", key_held, 0);

        // 3: bounce never reaches acceptance
        pulses = 0;
        run_frame(16'(1) << 10, 1'b0, "bnc1");
        run_frame(16'(1) << 10, 1'b0, "bnc2");
        run_frame('0, 1'b0, "bnc3");
        run_frame(16'(1) << 10, 1'b0, "bnc4");
        run_frame(16'(1) << 10, 1'b0, "bnc5");
        for (int f = 0; f < 2; f++) run_frame('0, 1'b0, "bnc_rel");
        check("bnc.pulses", pulses, 0);

        // 4: two keys together, lowest index wins
        pulses = 0;
        for (int f = 0; f < 4; f++) run_frame((16'(1) << 4) | (16'(1) << 11), 1'b0, "multi");
        for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "multi_rel");
        check("multi.pulses", pulses, 1);
        check("multi.code", key_code, 4);

        // 5: auto-repeat on (0,1) held for 14 frames
        pulses = 0;
        for (int f = 0; f < 14; f++) run_frame(16'(1) << 1, 1'b1, "rpt");
        for (int f = 0; f < 3; f++) run_frame('0, 1'b1, "rpt_rel");
        check("rpt.pulses", pulses, 6);
        check("rpt.code", key_code, 1);

        // 6: reset in the middle of confirmation
        pulses = 0;
        run_frame(16'(1) << 13, 1'b0, "rstc1");
        run_frame(16'(1) << 13, 1'b0, "rstc2");
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst.row", row_sweep, 4'b0001);
        check("midrst.valid", key_valid, 0);
        check("midrst.held", key_held, 0);
        check("midrst.code", key_code, 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(16'(1) << 13, 1'b0, "fresh1");
        run_frame(16'(1) << 13, 1'b0, "fresh2");
        check("fresh2.pulses", pulses, 0);
        run_frame(16'(1) << 13, 1'b0, "fresh3");
        check("fresh3.pulses", pulses, 1);
        check("fresh3.code", key_code, 13);
        for (int f = 0; f < 3; f++) run_frame('0, 1'b0, "fresh_rel");

        // Random streaky key activity against the model
        rm  = '0;
        ren = 1'b0;
        for (int f = 0; f < 60; f++) begin
            if (f % 8 == 0) ren = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            if (k >= 8) begin
                rm = 16'(1) << $urandom_range(0, 15);
                if (k == 9) rm = rm | (16'(1) << $urandom_range(0, 15));
            end else if (k >= 6) begin
                rm = '0;
            end
            run_frame(rm, ren, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
